// File: rtl/tlb_asid.sv
// Fully associative TLB with ASID tagging, mixed 4K/2M/1G pages, tree-PLRU
// replacement and registered lookup results.
module tlb_asid #(
    parameter int LG_N   = 3,
    parameter int ASID_W = 16,
    parameter int PA_W   = 56
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              req,
    input  logic [63:0]       va,
    input  logic [ASID_W-1:0] asid,
    input  logic [1:0]        priv,
    input  logic              is_store,
    input  logic              is_fetch,
    input  logic              sum,
    output logic              hit,
    output logic              fault,
    output logic              dirty,
    output logic [PA_W-1:0]   pa,
    input  logic              fill,
    input  logic [63:0]       fill_va,
    input  logic [ASID_W-1:0] fill_asid,
    input  logic [1:0]        fill_pgsize,
    input  logic [63:0]       fill_paddr,
    input  logic [5:0]        fill_perm,
    input  logic              flush,
    input  logic              flush_va_vld,
    input  logic [63:0]       flush_va,
    input  logic              flush_asid_vld,
    input  logic [ASID_W-1:0] flush_asid,
    output logic [63:0]       tlb_hits,
    output logic [63:0]       tlb_accesses
);

    localparam int N     = 1 << LG_N;
    localparam int PPN_W = PA_W - 12;
    localparam int P_R   = 0;
    localparam int P_W   = 1;
    localparam int P_X   = 2;
    localparam int P_U   = 3;
    localparam int P_G   = 4;
    localparam int P_D   = 5;

    logic [N-1:0]      valid;
    logic [ASID_W-1:0] e_asid [N];
    logic [27:0]       e_tag  [N];
    logic [1:0]        e_size [N];
    logic [PPN_W-1:0]  e_ppn  [N];
    logic [5:0]        e_perm [N];
    logic [N-2:0]      plru;

    // Tags hold va[39:12]; larger pages simply ignore their low tag bits.
    function automatic logic tag_eq(input logic [27:0] a, input logic [27:0] b,
                                    input logic [1:0] size);
        logic [27:0] mask;
        case (size)
            2'd0:    mask = 28'hFFC_0000;
            2'd1:    mask = 28'hFFF_FE00;
            default: mask = 28'hFFF_FFFF;
        endcase
        return ((a ^ b) & mask) == 28'h0;
    endfunction

    // Level k of the tree splits on way bit k; each bit points at the victim side.
    function automatic logic [N-2:0] plru_touch(input logic [N-2:0] bits,
                                                input logic [LG_N-1:0] way);
        int node;
        node = 1;
        for (int k = 0; k < LG_N; k++) begin
            bits[node-1] = ~way[k];
            node = 2 * node + int'(way[k]);
        end
        return bits;
    endfunction

    logic [N-1:0]      lk_match;
    logic [N-1:0]      fl_match;
    logic [N-1:0]      kill;
    logic [LG_N-1:0]   lk_idx;
    logic [LG_N-1:0]   fl_idx;
    logic [LG_N-1:0]   free_idx;
    logic [LG_N-1:0]   plru_victim;
    logic [LG_N-1:0]   victim;
    logic              lk_any;
    logic              lk_fault;
    logic [PA_W-1:0]   lk_pa;
    logic [N-2:0]      plru_next;
    logic              fill_do;
    logic              is_load;
    logic [5:0]        sel_perm;
    int                node;

    always_comb begin
        lk_match = '0;
        fl_match = '0;
        kill     = '0;
        for (int i = 0; i < N; i++) begin
            lk_match[i] = valid[i] & (e_perm[i][P_G] | (e_asid[i] == asid))
                        & tag_eq(e_tag[i], va[39:12], e_size[i]);
            fl_match[i] = valid[i] & (e_size[i] == fill_pgsize)
                        & (e_perm[i][P_G] | (e_asid[i] == fill_asid))
                        & tag_eq(e_tag[i], fill_va[39:12], fill_pgsize);
            case ({flush_va_vld, flush_asid_vld})
                2'b00:   kill[i] = 1'b1;
                2'b10:   kill[i] = tag_eq(e_tag[i], flush_va[39:12], e_size[i]);
                2'b01:   kill[i] = ~e_perm[i][P_G] & (e_asid[i] == flush_asid);
                default: kill[i] = ~e_perm[i][P_G] & (e_asid[i] == flush_asid)
                                 & tag_eq(e_tag[i], flush_va[39:12], e_size[i]);
            endcase
        end
    end

    // Descending scans so the lowest matching/free index is the one that sticks.
    always_comb begin
        lk_idx   = '0;
        fl_idx   = '0;
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (lk_match[i]) lk_idx = LG_N'(i);
            if (fl_match[i]) fl_idx = LG_N'(i);
            if (!valid[i])   free_idx = LG_N'(i);
        end
        plru_victim = '0;
        node = 1;
        for (int k = 0; k < LG_N; k++) begin
            plru_victim[k] = plru[node-1];
            node = 2 * node + int'(plru[node-1]);
        end
        if (|fl_match)
            victim = fl_idx;
        else if (!(&valid))
            victim = free_idx;
        else
            victim = plru_victim;
    end

    always_comb begin
        lk_any   = |lk_match;
        sel_perm = e_perm[lk_idx];
        is_load  = ~is_store & ~is_fetch;
        lk_fault = (is_fetch & ~sel_perm[P_X]) | (is_store & ~sel_perm[P_W])
                 | (is_load & ~sel_perm[P_R]) | (is_store & ~sel_perm[P_D])
                 | ((priv == 2'd0) & ~sel_perm[P_U])
                 | ((priv == 2'd1) & sel_perm[P_U] & (is_fetch | ~sum));
        lk_pa = {e_ppn[lk_idx], va[11:0]};
        case (e_size[lk_idx])
            2'd0:    lk_pa[29:0] = va[29:0];
            2'd1:    lk_pa[20:0] = va[20:0];
            default: ;
        endcase
    end

    // A fill in the same cycle as a hit is applied last so it ends up MRU.
    always_comb begin
        fill_do   = fill & (fill_pgsize != 2'd3) & ~flush;
        plru_next = plru;
        if (active & req & lk_any) plru_next = plru_touch(plru_next, lk_idx);
        if (fill_do)               plru_next = plru_touch(plru_next, victim);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid        <= '0;
            plru         <= '0;
            hit          <= 1'b0;
            fault        <= 1'b0;
            dirty        <= 1'b0;
            pa           <= '0;
            tlb_hits     <= '0;
            tlb_accesses <= '0;
        end else begin
            if (flush)
                valid <= valid & ~kill;
            else if (fill_do)
                valid[victim] <= 1'b1;
            plru <= plru_next;
            if (!active) begin
                hit   <= 1'b1;
                fault <= 1'b0;
                dirty <= 1'b0;
                pa    <= va[PA_W-1:0];
            end else begin
                hit   <= req & lk_any;
                fault <= req & lk_any & lk_fault;
                dirty <= req & lk_any & sel_perm[P_D];
                pa    <= lk_pa;
            end
            if (active & req) begin
                tlb_accesses <= tlb_accesses + 64'd1;
                if (lk_any) tlb_hits <= tlb_hits + 64'd1;
            end
        end
    end

    // Entry payload carries no reset; an entry is meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (!reset && fill_do) begin
            e_asid[victim] <= fill_asid;
            e_tag[victim]  <= fill_va[39:12];
            e_size[victim] <= fill_pgsize;
            e_ppn[victim]  <= fill_paddr[PA_W-1:12];
            e_perm[victim] <= fill_perm;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{va[63:40], fill_va[63:40], fill_va[11:0], flush_va[63:40],
                           flush_va[11:0], fill_paddr};

endmodule

// File: doc/tlb_asid.md
TLB_ASID -- requirements
Module: tlb_asid

Interface
REQ-001 SHALL have parameter LG_N, default 3, log2 of entry count (N=2^LG_N, fully associative, LG_N>=1).
REQ-002 SHALL have parameter ASID_W, default 16, address-space-ID width.
REQ-003 SHALL have parameter PA_W, default 56, physical address width.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 active  in  1  translation enabled.
REQ-007 req  in  1  lookup request.
REQ-008 va  in  64  lookup virtual address.
REQ-009 asid  in  ASID_W  current ASID.
REQ-010 priv  in  2  privilege: 0=U, 1=S.
REQ-011 is_store, is_fetch  in  1 each  access type; both low means load.
REQ-012 sum  in  1  supervisor may access U pages (loads/stores only).
REQ-013 hit, fault, dirty  out  1 each  registered lookup result.
REQ-014 pa  out  PA_W  registered physical address.
REQ-015 fill  in  1  write a page-walk result.
REQ-016 fill_va  in  64; fill_asid  in  ASID_W; fill_pgsize  in  2 (0=1G, 1=2M, 2=4K, 3=illegal).
REQ-017 fill_paddr  in  64; fill_perm  in  6, {d,g,u,x,w,r}.
REQ-018 flush  in  1; flush_va_vld  in  1; flush_va  in  64; flush_asid_vld  in  1; flush_asid  in  ASID_W.
REQ-019 tlb_hits, tlb_accesses  out  64 each  performance counters.

Function
REQ-020 Entry i matches when valid, (g or entry asid==asid), and tag matches by size: 4K va[39:12], 2M va[39:21], 1G va[39:30].
REQ-021 Multiple matches: lowest index wins.
REQ-022 Latency: hit/pa/fault/dirty SHALL update 1 cycle after the request, from pre-update state of that cycle.
REQ-023 pa: 1G {paddr[PA_W-1:30], va[29:0]}; 2M {paddr[PA_W-1:21], va[20:0]}; 4K {paddr[PA_W-1:12], va[11:0]}.
REQ-024 active=1: hit = req & any-match; on miss, fault=0, pa/dirty don't-care.
REQ-025 active=0: hit=1, fault=0, pa=va[PA_W-1:0].
REQ-026 fault on hit if: fetch & !x; store & !w; load & !r; store & !d; priv=0 & !u; priv=1 & u & (fetch | !sum).
REQ-027 Fill victim: existing entry matching fill_va/fill_asid/fill_pgsize (no duplicates); else lowest-index invalid entry; else tree-PLRU victim (N-1 bits).
REQ-028 fill with fill_pgsize=3 SHALL be ignored.
REQ-029 PLRU SHALL be marked on every active hit and on every fill; if both occur in one cycle, the fill update is applied last.
REQ-030 Flush single cycle: neither vld -> all entries invalid; va only -> entries whose tag matches flush_va at their size, any ASID; asid only -> non-global entries with that ASID; both -> non-global entries matching va and ASID.
REQ-031 flush and fill in the same cycle: flush applied, fill discarded.
REQ-032 tlb_accesses +1 per cycle with active&req; tlb_hits +1 when additionally any entry matches; both wrap modulo 2^64.

Reset
REQ-033 On reset all entries SHALL be invalid, PLRU bits 0, counters 0, hit=0, fault=0, dirty=0, pa=0.
REQ-034 reset SHALL override concurrent fill, flush and req.

Verification
REQ-035 Fill 4K va=0x1234_5000, asid=5, paddr=0x8_0000_0000, perm=0x23 (d,w,r); next cycle req va=0x1234_5ABC, asid=5 -> hit=1, pa=0x8_0000_0ABC, fault=0; asid=6 -> hit=0.
REQ-036 Fill 1G global entry va=0x4000_0000 -> req va=0x7FFF_FFF0 any ASID hits, pa low 30 bits = 0x3FFF_FFF0; store with w=0 -> fault=1; priv=0 with u=0 -> fault=1.
REQ-037 LG_N=2: fill 4 distinct pages, hit entries 0,1,2 in order, fill 5th -> entry 3 replaced; refill of same va/asid overwrites in place, no duplicate.
REQ-038 Flush asid only=5 -> asid-5 non-global entries miss, global and asid-7 entries still hit; flush+fill same cycle -> filled page misses.
REQ-039 active=0, req va=0x1_2345_6789 -> hit=1, pa=0x1_2345_6789, tlb_accesses unchanged; reset after 10 counted accesses -> counters 0, all lookups miss.
